// File: rtl/spu_boot_loader_pkg.sv
// Shared types for the SPU boot loader: word/quad types, segment codes,
// FSM states and header field extraction.
package spu_boot_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned QUAD_W  = 128;
  localparam int unsigned FIELD_W = 15;

  typedef logic [0:WORD_W-1]  word_t;
  typedef logic [0:QUAD_W-1]  quad_t;
  typedef logic [0:FIELD_W-1] field_t;

  typedef enum logic [1:0] {
    SEG_INSTR = 2'b00,
    SEG_RF    = 2'b01,
    SEG_LS    = 2'b10,
    SEG_GO    = 2'b11
  } seg_t;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_INSTR = 3'd1,
    ST_QUAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Header layout: type in the two MSBs, then 15-bit address, then 15-bit count.
  function automatic seg_t hdr_type(input word_t hd);
    return seg_t'(hd[0:1]);
  endfunction

  function automatic field_t hdr_addr(input word_t hd);
    return hd[2:16];
  endfunction

  function automatic field_t hdr_count(input word_t hd);
    return hd[17:31];
  endfunction

endpackage

// File: rtl/spu_boot_loader_if.sv
// Host word-stream handshake between the host and the boot loader.
interface spu_boot_loader_if;
  import spu_boot_pkg::*;

  word_t host_data;
  logic  host_valid;
  logic  host_ready;

  modport master (output host_data, output host_valid, input host_ready);
  modport slave  (input host_data, input host_valid, output host_ready);

endinterface

// File: rtl/spu_boot_loader_quad_packer.sv
// Collects four 32-bit payload words into one 128-bit quadword, first word in the MSBs.
module spu_quad_packer
  import spu_boot_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  word_valid,
  input  word_t word,
  output logic  quad_valid,
  output quad_t quad_data
);

  logic [1:0]            word_idx;
  logic [0:3*WORD_W-1]   shift_q;

  // The fourth word bypasses the buffer so the quad is available on the beat itself.
  assign quad_valid = word_valid && (word_idx == 2'd3);
  assign quad_data  = {shift_q, word};

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      word_idx <= '0;
      shift_q  <= '0;
    end else if (word_valid) begin
      word_idx <= word_idx + 2'd1;
      shift_q  <= {shift_q[WORD_W:3*WORD_W-1], word};
    end
  end

endmodule

// File: rtl/spu_boot_loader.sv
// Host-side program/data loader: decodes segment headers from the host word stream and
// drives the SPU instruction, register-file and local-store preload ports.
module spu_boot_loader
  import spu_boot_pkg::*;
#(
  parameter int unsigned INSTR_AW = 10,
  parameter int unsigned RF_AW    = 10,
  parameter int unsigned RF_DEPTH = 128,
  parameter int unsigned LS_AW    = 15,
  parameter int unsigned LS_STEP  = 16
) (
  input  logic                clk,
  input  logic                rst,
  spu_boot_loader_if.slave    host,
  output logic                load_en,
  output logic [0:INSTR_AW-1] instr_load_addr,
  output word_t               instruction_in,
  output logic                preload_en,
  output logic [0:RF_AW-1]    preload_addr,
  output quad_t               preload_values,
  output logic                preload_LS_en,
  output logic [0:LS_AW-1]    preload_LS_addr,
  output quad_t               preload_LS_data,
  output logic                core_hold,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned LS_LSB = $clog2(LS_STEP);

  state_t              state, next_state;
  logic                ready, beat;
  word_t               hd;
  seg_t                hd_type;
  field_t              hd_addr, hd_count;
  logic [0:FIELD_W]    rf_end;
  logic                hdr_ok;
  field_t              remaining;
  logic                last_item;
  logic                seg_is_ls;
  logic [0:INSTR_AW-1] instr_ptr;
  logic [0:RF_AW-1]    rf_ptr;
  logic [0:LS_AW-1]    ls_ptr;
  logic                pack_clear, pack_valid, quad_valid;
  quad_t               quad_data;

  assign hd        = host.host_data;
  assign hd_type   = hdr_type(hd);
  assign hd_addr   = hdr_addr(hd);
  assign hd_count  = hdr_count(hd);

  assign ready           = (state == ST_HDR) || (state == ST_INSTR) || (state == ST_QUAD);
  assign host.host_ready = ready;
  assign beat            = host.host_valid && ready;

  assign rf_end    = {1'b0, hd_addr} + {1'b0, hd_count};
  assign last_item = (remaining == field_t'(1));

  always_comb begin
    hdr_ok = 1'b1;
    unique case (hd_type)
      SEG_RF:  hdr_ok = (rf_end <= (FIELD_W+1)'(RF_DEPTH));
      SEG_LS:  hdr_ok = (hd_addr[FIELD_W-LS_LSB:FIELD_W-1] == '0);
      default: hdr_ok = 1'b1;
    endcase
  end

  // Packer only sees payload beats; returning to HDR drops any partial quad.
  assign pack_clear = (state == ST_HDR);
  assign pack_valid = beat && (state == ST_QUAD);

  spu_quad_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .word_valid (pack_valid),
    .word       (hd),
    .quad_valid (quad_valid),
    .quad_data  (quad_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_HDR;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_hold  = 1'b1;
    unique case (state)
      ST_HDR: begin
        if (beat) begin
          if (hd_type == SEG_GO)         next_state = ST_DONE;
          else if (hd_count == '0)       next_state = ST_HDR;
          else if (!hdr_ok)              next_state = ST_ERR;
          else if (hd_type == SEG_INSTR) next_state = ST_INSTR;
          else                           next_state = ST_QUAD;
        end
      end
      ST_INSTR: begin
        busy = 1'b1;
        if (beat && last_item) next_state = ST_HDR;
      end
      ST_QUAD: begin
        busy = 1'b1;
        if (quad_valid && last_item) next_state = ST_HDR;
      end
      ST_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: next_state = ST_ERR;
    endcase
  end

  // Output registers are separate from the packer buffer, so the host is never stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_en         <= 1'b0;
      instr_load_addr <= '0;
      instruction_in  <= '0;
      preload_en      <= 1'b0;
      preload_addr    <= '0;
      preload_values  <= '0;
      preload_LS_en   <= 1'b0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
      remaining       <= '0;
      seg_is_ls       <= 1'b0;
      instr_ptr       <= '0;
      rf_ptr          <= '0;
      ls_ptr          <= '0;
    end else begin
      load_en       <= 1'b0;
      preload_en    <= 1'b0;
      preload_LS_en <= 1'b0;
      unique case (state)
        ST_HDR: begin
          if (beat) begin
            remaining <= hd_count;
            seg_is_ls <= (hd_type == SEG_LS);
            instr_ptr <= hd_addr[FIELD_W-INSTR_AW:FIELD_W-1];
            rf_ptr    <= hd_addr[FIELD_W-RF_AW:FIELD_W-1];
            ls_ptr    <= hd_addr[FIELD_W-LS_AW:FIELD_W-1];
          end
        end
        ST_INSTR: begin
          if (beat) begin
            load_en         <= 1'b1;
            instr_load_addr <= instr_ptr;
            instruction_in  <= hd;
            instr_ptr       <= instr_ptr + INSTR_AW'(1);
            remaining       <= remaining - field_t'(1);
          end
        end
        ST_QUAD: begin
          if (quad_valid) begin
            remaining <= remaining - field_t'(1);
            if (seg_is_ls) begin
              preload_LS_en   <= 1'b1;
              preload_LS_addr <= ls_ptr;
              preload_LS_data <= quad_data;
              ls_ptr          <= ls_ptr + LS_AW'(LS_STEP);
            end else begin
              preload_en     <= 1'b1;
              preload_addr   <= rf_ptr;
              preload_values <= quad_data;
              rf_ptr         <= rf_ptr + RF_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_boot_loader.sv
// Directed bench for spu_boot_loader: an image-level model predicts every write and the
// final status; one negedge process checks each strobe against it.
module tb_spu_boot_loader;

  typedef struct {
    int          kind;   // 0 instr, 1 rf, 2 ls
    int unsigned addr;
    logic [127:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spu_boot_loader_if host_bus();

  logic         load_en, preload_en, preload_LS_en;
  logic [0:9]   instr_load_addr, preload_addr;
  logic [0:31]  instruction_in;
  logic [0:127] preload_values, preload_LS_data;
  logic [0:14]  preload_LS_addr;
  logic         core_hold, busy, done, error;

  spu_boot_loader #(
    .INSTR_AW (10),
    .RF_AW    (10),
    .RF_DEPTH (128),
    .LS_AW    (15),
    .LS_STEP  (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host_bus),
    .load_en         (load_en),
    .instr_load_addr (instr_load_addr),
    .instruction_in  (instruction_in),
    .preload_en      (preload_en),
    .preload_addr    (preload_addr),
    .preload_values  (preload_values),
    .preload_LS_en   (preload_LS_en),
    .preload_LS_addr (preload_LS_addr),
    .preload_LS_data (preload_LS_data),
    .core_hold       (core_hold),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  int errors = 0;
  int checks = 0;

  wr_t         exp_q[$];
  wr_t         got_q[$];
  wr_t         ref_q[$];
  logic [31:0] img[$];
  int          m_term;   // 0 running, 1 done, 2 error
  int          m_tidx;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [31:0] hdr(input int ty, input int a, input int c);
    logic [31:0] h;
    h = {ty[1:0], a[14:0], c[14:0]};
    return h;
  endfunction

  // Walks the image with the header rules and appends every write it implies to exp_q.
  task automatic model_build();
    int i, ty, a, c;
    logic [31:0] h;
    i = 0; m_term = 0; m_tidx = 0;
    while (i < img.size() && m_term == 0) begin
      h = img[i]; ty = int'(h[31:30]); a = int'(h[29:15]); c = int'(h[14:0]);
      i++;
      if (ty == 3) begin m_term = 1; m_tidx = i - 1; end
      else if (c != 0) begin
        if (ty == 0) begin
          for (int k = 0; k < c; k++)
            exp_q.push_back('{0, (a + k) % 1024, {96'b0, img[i+k]}});
          i += c;
        end else if (ty == 1 && a + c > 128) begin
          m_term = 2; m_tidx = i - 1;
        end else if (ty == 2 && a % 16 != 0) begin
          m_term = 2; m_tidx = i - 1;
        end else begin
          for (int k = 0; k < c; k++) begin
            logic [127:0] q;
            q = {img[i+4*k], img[i+4*k+1], img[i+4*k+2], img[i+4*k+3]};
            if (ty == 1) exp_q.push_back('{1, a + k, q});
            else         exp_q.push_back('{2, (a + 16*k) % 32768, q});
          end
          i += 4*c;
        end
      end
    end
  endtask

  task automatic check_write(input int kind, input int unsigned addr, input logic [127:0] data);
    wr_t e;
    got_q.push_back('{kind, addr, data});
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_write: got kind %0d addr %0h, expected no write", kind, addr);
    end else begin
      e = exp_q.pop_front();
      chk("write_kind", 128'(kind), 128'(e.kind));
      chk("write_addr", 128'(addr), 128'(e.addr));
      chk("write_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    int n;
    n = int'(load_en) + int'(preload_en) + int'(preload_LS_en);
    chk("strobe_onehot", 128'(n <= 1), 128'(1));
    if (load_en)       check_write(0, int'(instr_load_addr), {96'b0, instruction_in});
    if (preload_en)    check_write(1, int'(preload_addr), preload_values);
    if (preload_LS_en) check_write(2, int'(preload_LS_addr), preload_LS_data);
  end

  task automatic send_word(input logic [31:0] w, input bit gapped);
    int g;
    g = 0;
    if (gapped)
      while (g < 4 && $urandom_range(0, 1) == 1) begin @(negedge clk); g++; end
    @(negedge clk);
    host_bus.host_data  = w;
    host_bus.host_valid = 1'b1;
    chk("host_ready", 128'(host_bus.host_ready), 128'(1));
    @(posedge clk);
    #1 host_bus.host_valid = 1'b0;
  endtask

  task automatic run_image(input bit gapped);
    int n;
    model_build();
    n = (m_term != 0) ? m_tidx + 1 : img.size();
    for (int i = 0; i < n; i++) send_word(img[i], gapped);
    @(negedge clk); #1;
    chk("done",       128'(done),                128'(m_term == 1));
    chk("error",      128'(error),               128'(m_term == 2));
    chk("core_hold",  128'(core_hold),           128'(m_term != 1));
    chk("ready_after",128'(host_bus.host_ready), 128'(m_term == 0));
    repeat (2) @(negedge clk);
    #1 chk("pending_writes", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic chk_reset();
    chk("rst_load_en",    128'(load_en), 128'(0));
    chk("rst_preload_en", 128'(preload_en), 128'(0));
    chk("rst_ls_en",      128'(preload_LS_en), 128'(0));
    chk("rst_instr_addr", 128'(instr_load_addr), 128'(0));
    chk("rst_instr_data", 128'(instruction_in), 128'(0));
    chk("rst_rf_addr",    128'(preload_addr), 128'(0));
    chk("rst_rf_data",    preload_values, 128'(0));
    chk("rst_ls_addr",    128'(preload_LS_addr), 128'(0));
    chk("rst_ls_data",    preload_LS_data, 128'(0));
    chk("rst_busy",       128'(busy), 128'(0));
    chk("rst_done",       128'(done), 128'(0));
    chk("rst_error",      128'(error), 128'(0));
    chk("rst_core_hold",  128'(core_hold), 128'(1));
    chk("rst_ready",      128'(host_bus.host_ready), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    host_bus.host_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk); #1;
    chk_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    host_bus.host_data  = '0;
    host_bus.host_valid = 1'b0;
    do_reset();

    // 1: INSTR addr 5 cnt 3
    got_q.delete();
    img = '{hdr(0, 5, 3), 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    run_image(0);
    chk("t1_count", 128'(got_q.size()), 128'(3));
    chk("t1_addr0", 128'(got_q[0].addr), 128'(5));
    chk("t1_data0", got_q[0].data, 128'h0000_0000_0000_0000_0000_0000_AAAA_0001);
    chk("t1_addr2", 128'(got_q[2].addr), 128'(7));

    // 2: RF addr 10 cnt 2, then overflowing RF header
    got_q.delete();
    img = '{hdr(1, 10, 2),
            32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
            32'h2000_0000, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003};
    run_image(0);
    chk("t2_addr0", 128'(got_q[0].addr), 128'(10));
    chk("t2_quad0", got_q[0].data, 128'h1000_0000_1000_0001_1000_0002_1000_0003);
    chk("t2_addr1", 128'(got_q[1].addr), 128'(11));
    img = '{hdr(1, 127, 2)};
    run_image(0);
    @(negedge clk);
    host_bus.host_data  = 32'hDEAD_BEEF;
    host_bus.host_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("t2_error_sticky", 128'(error), 128'(1));
    do_reset();

    // 3: LS wrap at top of local store, then misaligned LS header
    got_q.delete();
    img = '{hdr(2, 15'h7FF0, 2),
            32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003,
            32'h4000_0000, 32'h4000_0001, 32'h4000_0002, 32'h4000_0003};
    run_image(0);
    chk("t3_addr0", 128'(got_q[0].addr), 128'(15'h7FF0));
    chk("t3_addr1", 128'(got_q[1].addr), 128'(0));
    img = '{hdr(2, 4, 1)};
    run_image(0);
    do_reset();

    // 4: gapped host_valid must produce the same write sequence as a gapless run
    img = '{hdr(0, 1022, 4), 32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003,
            hdr(1, 0, 1), 32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003,
            hdr(2, 15'h0100, 2),
            32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003,
            32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
    got_q.delete();
    run_image(0);
    ref_q = got_q;
    chk("t4_instr_wrap", 128'(ref_q[2].addr), 128'(0));
    do_reset();
    got_q.delete();
    run_image(1);
    chk("t4_gap_count", 128'(got_q.size()), 128'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
      chk("t4_gap_addr", 128'(got_q[i].addr), 128'(ref_q[i].addr));
      chk("t4_gap_data", got_q[i].data, ref_q[i].data);
    end

    // 5: count=0 header writes nothing, GO releases the core
    got_q.delete();
    img = '{hdr(0, 50, 0), hdr(3, 0, 0)};
    run_image(0);
    chk("t5_no_writes", 128'(got_q.size()), 128'(0));
    chk("t5_core_hold", 128'(core_hold), 128'(0));
    do_reset();

    // 6: reset in the middle of a quad discards it; fresh segment loads normally
    got_q.delete();
    send_word(hdr(1, 20, 1), 0);
    @(negedge clk); #1 chk("t6_busy", 128'(busy), 128'(1));
    send_word(32'h9000_0000, 0);
    send_word(32'h9000_0001, 0);
    do_reset();
    chk("t6_no_partial", 128'(got_q.size()), 128'(0));
    img = '{hdr(1, 20, 1), 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    run_image(0);
    chk("t6_addr", 128'(got_q[0].addr), 128'(20));
    chk("t6_quad", got_q[0].data, 128'hA000_0000_A000_0001_A000_0002_A000_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
